// File: rtl/tv80_io_fabric_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tv80_io_pkg
// Description : Shared types and constants for the TV80 IO/memory bus fabric.
// Revision    : 1.0 - initial release
// ============================================================================
package tv80_io_pkg;

    // Bus fabric sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WS   = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Per-channel address space selector values
    localparam logic SP_MEM = 1'b0;
    localparam logic SP_IO  = 1'b1;

    // Width of a channel index; a single channel still needs one bit
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tv80_io_fabric_match.sv
`default_nettype none
// ============================================================================
// Module      : tv80_io_match
// Description : Combinational address comparator for all channels followed
//               by a priority encoder (lowest matching channel wins).
// Revision    : 1.0 - initial release
// ============================================================================
module tv80_io_match
    import tv80_io_pkg::*;
#(
    parameter int                NCH   = 4,
    parameter logic [NCH*16-1:0] BASE  = {NCH{16'h0000}},
    parameter logic [NCH*16-1:0] MASK  = {NCH{16'hFFFF}},
    parameter logic [NCH-1:0]    SPACE = {NCH{1'b1}},
    parameter int                CW    = chan_width(NCH)
) (
    input  logic [15:0]   i_addr,
    input  logic          i_is_io,
    output logic          o_hit,
    output logic [CW-1:0] o_chan
);

    logic [15:0]    w_eff_addr;
    logic [NCH-1:0] w_match;
    logic           w_space;

    // IO cycles only decode the low address byte
    assign w_eff_addr = i_is_io ? {8'h00, i_addr[7:0]} : i_addr;
    assign w_space    = i_is_io ? SP_IO : SP_MEM;

    for (genvar i = 0; i < NCH; i++) begin : g_cmp
        assign w_match[i] = (((w_eff_addr ^ BASE[16*i +: 16]) & MASK[16*i +: 16]) == 16'h0000)
                            && (SPACE[i] == w_space);
    end

    // Scan from the top down so the lowest matching index is the last written
    always_comb begin
        o_hit  = 1'b0;
        o_chan = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit  = 1'b1;
                o_chan = CW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tv80_io_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tv80_io_fabric
// Description : TV80 bus fabric. Decodes CPU memory/IO cycles onto NCH
//               peripheral channels with wait-state insertion, device ready
//               handshake, ready timeout and a registered read-data mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tv80_io_fabric
    import tv80_io_pkg::*;
#(
    parameter int                NCH       = 4,
    parameter logic [NCH*16-1:0] BASE      = {NCH{16'h0000}},
    parameter logic [NCH*16-1:0] MASK      = {NCH{16'hFFFF}},
    parameter logic [NCH-1:0]    SPACE     = {NCH{1'b1}},
    parameter logic [NCH*4-1:0]  WS        = {NCH{4'd0}},
    parameter logic [7:0]        TIMEOUT   = 8'd255,
    parameter logic [7:0]        IACK_VEC  = 8'hFF,
    parameter logic [7:0]        DFLT_DATA = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mreq_n,
    input  logic             iorq_n,
    input  logic             m1_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [15:0]      addr,
    input  logic [7:0]       wr_data,
    output logic [7:0]       cpu_di,
    output logic             wait_n,
    output logic [NCH-1:0]   ch_cs,
    output logic [NCH-1:0]   ch_rd_stb,
    output logic [NCH-1:0]   ch_wr_stb,
    output logic [7:0]       ch_wr_data,
    input  logic [NCH-1:0]   ch_rdy,
    input  logic [NCH*8-1:0] ch_rd_data,
    output logic             bus_err
);

    localparam int CW = chan_width(NCH);

    localparam logic [1:0] c_IDLE = ST_IDLE;
    localparam logic [1:0] c_WS   = ST_WS;
    localparam logic [1:0] c_HOLD = ST_HOLD;
    localparam logic [1:0] c_DONE = ST_DONE;

    logic [1:0]    r_state;
    logic [CW-1:0] r_chan;
    logic [3:0]    r_ws_cnt;
    logic [7:0]    r_to_cnt;
    logic          r_is_rd;

    logic           w_intack;
    logic           w_active;
    logic           w_hit;
    logic [CW-1:0]  w_chan;
    logic [NCH-1:0] w_onehot;
    logic [3:0]     w_ws;
    logic           w_rdy;
    logic [7:0]     w_rd_byte;

    // Int-ack is recognised regardless of rd_n/wr_n; IO wins over memory
    assign w_intack  = !m1_n && !iorq_n;
    assign w_active  = ((!mreq_n || !iorq_n) && (!rd_n || !wr_n) && m1_n) || w_intack;
    assign w_onehot  = NCH'(1) << w_chan;
    assign w_ws      = WS[4*w_chan +: 4];
    assign w_rdy     = ch_rdy[r_chan];
    assign w_rd_byte = ch_rd_data[8*r_chan +: 8];

    tv80_io_match #(
        .NCH   (NCH),
        .BASE  (BASE),
        .MASK  (MASK),
        .SPACE (SPACE),
        .CW    (CW)
    ) u_match (
        .i_addr  (addr),
        .i_is_io (!iorq_n),
        .o_hit   (w_hit),
        .o_chan  (w_chan)
    );

    // Access sequencer: decode, wait states, ready/timeout, hold until CPU ends the cycle.
    // Reset parks in DONE so an access already in flight is not re-decoded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_DONE;
            r_chan     <= '0;
            r_ws_cnt   <= 4'd0;
            r_to_cnt   <= 8'd0;
            r_is_rd    <= 1'b0;
            cpu_di     <= DFLT_DATA;
            wait_n     <= 1'b1;
            ch_cs      <= '0;
            ch_rd_stb  <= '0;
            ch_wr_stb  <= '0;
            ch_wr_data <= 8'h00;
            bus_err    <= 1'b0;
        end else begin
            ch_rd_stb <= '0;
            ch_wr_stb <= '0;
            bus_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_active) begin
                        if (w_intack) begin
                            cpu_di  <= IACK_VEC;
                            r_state <= c_DONE;
                        end else if (w_hit) begin
                            r_chan   <= w_chan;
                            r_is_rd  <= !rd_n;
                            ch_cs    <= w_onehot;
                            wait_n   <= 1'b0;
                            r_ws_cnt <= w_ws;
                            r_to_cnt <= 8'd0;
                            if (!rd_n) begin
                                ch_rd_stb <= w_onehot;
                            end else begin
                                ch_wr_stb  <= w_onehot;
                                ch_wr_data <= wr_data;
                            end
                            r_state <= (w_ws == 4'd0) ? c_HOLD : c_WS;
                        end else begin
                            cpu_di  <= DFLT_DATA;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_WS: begin
                    r_ws_cnt <= r_ws_cnt - 4'd1;
                    if (r_ws_cnt == 4'd1) begin
                        r_to_cnt <= 8'd0;
                        r_state  <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (w_rdy) begin
                        if (r_is_rd) begin
                            cpu_di <= w_rd_byte;
                        end
                        wait_n  <= 1'b1;
                        r_state <= c_DONE;
                    end else if ((r_to_cnt + 8'd1) == TIMEOUT) begin
                        // Device held off for TIMEOUT cycles: release the CPU with default data
                        bus_err <= 1'b1;
                        cpu_di  <= DFLT_DATA;
                        wait_n  <= 1'b1;
                        r_state <= c_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    if (!w_active) begin
                        ch_cs   <= '0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_DONE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tv80_io_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_tv80_io_fabric
// Description : Self-checking bench for tv80_io_fabric. Directed cases plus
//               randomized accesses checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tv80_io_fabric;

    localparam int NCH = 4;
    localparam logic [7:0] c_TO   = 8'd255;
    localparam logic [7:0] c_IACK = 8'hC7;
    localparam logic [7:0] c_DFLT = 8'hFF;

    // Channel map: ch0 mem 0x0000-0x007F, ch1 IO 0x18-0x1F, ch2 IO 0x30-0x3F,
    // ch3 mem 0x0000-0x00FF (shadowed by ch0 below 0x80)
    logic [15:0] m_base  [NCH] = '{16'h0000, 16'h0018, 16'h0030, 16'h0020};
    logic [15:0] m_mask  [NCH] = '{16'hFF80, 16'h00F8, 16'hFFF0, 16'hFF00};
    bit          m_space [NCH] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int          m_ws    [NCH] = '{0, 0, 3, 1};

    logic             clk = 1'b0;
    logic             reset;
    logic             mreq_n, iorq_n, m1_n, rd_n, wr_n;
    logic [15:0]      addr;
    logic [7:0]       wr_data;
    logic [7:0]       cpu_di;
    logic             wait_n;
    logic [NCH-1:0]   ch_cs, ch_rd_stb, ch_wr_stb, ch_rdy;
    logic [7:0]       ch_wr_data;
    logic [NCH*8-1:0] ch_rd_data;
    logic             bus_err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] model_di;

    tv80_io_fabric #(
        .NCH       (NCH),
        .BASE      ({16'h0020, 16'h0030, 16'h0018, 16'h0000}),
        .MASK      ({16'hFF00, 16'hFFF0, 16'h00F8, 16'hFF80}),
        .SPACE     (4'b0110),
        .WS        ({4'd1, 4'd3, 4'd0, 4'd0}),
        .TIMEOUT   (c_TO),
        .IACK_VEC  (c_IACK),
        .DFLT_DATA (c_DFLT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mreq_n     (mreq_n),
        .iorq_n     (iorq_n),
        .m1_n       (m1_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .addr       (addr),
        .wr_data    (wr_data),
        .cpu_di     (cpu_di),
        .wait_n     (wait_n),
        .ch_cs      (ch_cs),
        .ch_rd_stb  (ch_rd_stb),
        .ch_wr_stb  (ch_wr_stb),
        .ch_wr_data (ch_wr_data),
        .ch_rdy     (ch_rdy),
        .ch_rd_data (ch_rd_data),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address decode rule: lowest channel whose space agrees and whose masked bits match
    function automatic int model_decode(input bit io, input logic [15:0] a);
        logic [15:0] ea;
        ea = io ? {8'h00, a[7:0]} : a;
        for (int i = 0; i < NCH; i++) begin
            if (m_space[i] == io && ((ea ^ m_base[i]) & m_mask[i]) == 16'h0000) return i;
        end
        return -1;
    endfunction

    task automatic idle_bus();
        mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full CPU access; dly = not-ready HOLD cycles, nv = device never ready
    task automatic do_access(input bit ia, input bit io, input bit both, input bit rd,
                             input logic [15:0] a, input logic [7:0] wd,
                             input int dly, input bit nv);
        int ch, ws, exp_stall, c, low, good, bad, errs;
        bit hit, seen;
        logic [7:0] wdat;
        logic [NCH-1:0] exp_cs;
        ch  = ia ? -1 : model_decode(io || both, a);
        hit = (ch >= 0);
        ws  = hit ? m_ws[ch] : 0;
        exp_cs    = hit ? (NCH'(1) << ch) : '0;
        exp_stall = !hit ? 0 : (nv ? ws + int'(c_TO) : ws + dly + 1);
        ch_rd_data = {$urandom};
        if (ia)             model_di = c_IACK;
        else if (!hit || nv) model_di = c_DFLT;
        else if (rd)        model_di = ch_rd_data[8*ch +: 8];

        addr = a; wr_data = wd; ch_rdy = '1;
        if (hit) ch_rdy[ch] = 1'b0;
        if (ia) begin
            iorq_n = 1'b0; m1_n = 1'b0;
        end else begin
            m1_n = 1'b1;
            if (io || both) iorq_n = 1'b0;
            if (!io || both) mreq_n = 1'b0;
            if (rd) rd_n = 1'b0; else wr_n = 1'b0;
        end

        c = 0; low = 0; good = 0; bad = 0; errs = 0; seen = 1'b0; wdat = 8'hxx;
        while (1) begin
            cycle();
            c++;
            if (!wait_n) begin low++; seen = 1'b1; end
            for (int i = 0; i < NCH; i++) begin
                if (ch_rd_stb[i]) begin if (hit && rd && i == ch) good++; else bad++; end
                if (ch_wr_stb[i]) begin if (hit && !rd && i == ch) good++; else bad++; end
            end
            if (ch_wr_stb != '0) wdat = ch_wr_data;
            if (bus_err) errs++;
            if (hit) ch_rdy[ch] = !nv && (low >= ws + 1 + dly);
            if ((seen && wait_n) || (!seen && c >= 3) || c > 700) break;
        end
        check("stall", low, exp_stall);
        check("stb_ok", good, hit ? 1 : 0);
        check("stb_bad", bad, 0);
        check("bus_err", errs, (hit && nv) ? 1 : 0);
        if (hit && !rd) check("wr_data", wdat, wd);
        check("cpu_di", cpu_di, model_di);
        cycle(); cycle();
        check("cs_hold", ch_cs, exp_cs);
        check("di_hold", cpu_di, model_di);
        idle_bus();
        ch_rdy = '1;
        cycle();
        check("cs_end", ch_cs, '0);
        check("wait_end", wait_n, 1'b1);
        cycle();
    endtask

    initial begin
        bit io, rd, ia, nv;
        logic [15:0] a;
        int dly, sel, rst_stb, rst_low;

        idle_bus();
        reset = 1'b1; addr = '0; wr_data = '0; ch_rdy = '1; ch_rd_data = '0;
        model_di = c_DFLT;
        cycle(); cycle();
        check("rst_di", cpu_di, c_DFLT);
        check("rst_wait", wait_n, 1'b1);
        check("rst_cs", ch_cs, '0);
        check("rst_stb", {ch_rd_stb, ch_wr_stb}, '0);
        check("rst_wdata", ch_wr_data, 8'h00);
        check("rst_err", bus_err, 1'b0);
        reset = 1'b0;
        cycle(); cycle();

        // Directed scenarios
        do_access(0, 1, 0, 0, 16'h001B, 8'hA5, 0, 0);   // IO write ch1, WS=0
        do_access(0, 1, 0, 1, 16'h5532, 8'h00, 0, 0);   // IO read ch2, WS=3, upper byte ignored
        do_access(0, 0, 0, 1, 16'h0010, 8'h00, 10, 0);  // mem read ch0, rdy late by 10
        do_access(0, 0, 0, 1, 16'h0005, 8'h00, 0, 1);   // mem read ch0, timeout
        do_access(0, 1, 0, 1, 16'h0040, 8'h00, 0, 0);   // unmatched IO read
        do_access(1, 0, 0, 0, 16'h0000, 8'h00, 0, 0);   // interrupt acknowledge
        do_access(0, 0, 0, 0, 16'h0085, 8'h3C, 2, 0);   // mem write ch3, WS=1
        do_access(0, 1, 1, 1, 16'h001C, 8'h00, 1, 0);   // mreq and iorq both low: IO wins

        // Overlap ch0/ch3 at 0x20, reset while device stalls
        ch_rd_data = {$urandom};
        ch_rdy = 4'b1110;
        addr = 16'h0020; mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b1;
        cycle(); cycle(); cycle();
        check("ovl_cs", ch_cs, 4'b0001);
        check("ovl_wait", wait_n, 1'b0);
        reset = 1'b1;
        cycle();
        check("mid_rst_di", cpu_di, c_DFLT);
        check("mid_rst_wait", wait_n, 1'b1);
        check("mid_rst_cs", ch_cs, '0);
        cycle();
        reset = 1'b0;
        rst_stb = 0; rst_low = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (ch_rd_stb != '0 || ch_wr_stb != '0) rst_stb++;
            if (!wait_n) rst_low++;
        end
        check("post_rst_stb", rst_stb, 0);
        check("post_rst_wait", rst_low, 0);
        idle_bus();
        ch_rdy = '1;
        model_di = c_DFLT;
        cycle(); cycle();

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            ia  = (sel == 0);
            nv  = (sel == 1);
            io  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 12);
            if (io) begin
                case ($urandom_range(0, 3))
                    0:       a = {8'($urandom), 8'h18 + 8'($urandom_range(0, 7))};
                    1:       a = {8'($urandom), 8'h30 + 8'($urandom_range(0, 15))};
                    2:       a = {8'($urandom), 8'h40};
                    default: a = 16'($urandom);
                endcase
            end else begin
                a = ($urandom_range(0, 3) != 0) ? {8'h00, 8'($urandom)} : 16'($urandom);
            end
            do_access(ia, io, 0, rd, a, 8'($urandom), dly, nv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
